// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: posted-write FIFO between data cache and data memory; define WBUF_FORWARD_EN to forward reads from queued writes
module dcache_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [5:0]  MEM_ADDRESS,
  input  logic [31:0] MEM_WRITEDATA,
  output logic [31:0] MEM_READDATA,
  output logic        MEM_BUSYWAIT,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [5:0]  DMEM_ADDRESS,
  output logic [31:0] DMEM_WRITEDATA,
  input  logic [31:0] DMEM_READDATA,
  input  logic        DMEM_BUSYWAIT,
  output logic        WBUF_EMPTY
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, DRAIN, FETCH} state_t;
  state_t state_q, state_d;
  logic [5:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic ack_q, ack_d, wdone_q, wdone_d, seen_q, seen_d, empty_q, empty_d;
  logic rd_q, rd_d, wr_q, wr_d;
  logic [5:0] daddr_q, daddr_d;
  logic [31:0] dwdata_q, dwdata_d, rdata_q, rdata_d;
  logic wr_req, rd_req, push, pop, done, hit, fetch_ok;
  logic [31:0] fwd;

  assign wr_req = MEM_WRITE & ~ack_q & ~wdone_q;
  assign rd_req = MEM_READ & ~ack_q & ~wr_req;
  assign push = wr_req & (count_q != CW'(DEPTH));
  assign done = (rd_q | wr_q) & ~DMEM_BUSYWAIT & seen_q;
  assign pop = done & wr_q;

`ifdef WBUF_FORWARD_EN
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && addr_q[head_q + AW'(i)] == MEM_ADDRESS) begin
        hit = 1'b1;
        fwd = data_q[head_q + AW'(i)];
      end
    end
  end
  assign fetch_ok = rd_req & ~hit;
`else
  assign hit = 1'b0;
  assign fwd = '0;
  assign fetch_ok = rd_req & (count_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    head_d = pop ? head_q + AW'(1) : head_q;
    tail_d = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    rd_d = rd_q;
    wr_d = wr_q;
    daddr_d = daddr_q;
    dwdata_d = dwdata_q;
    ack_d = (push & ~MEM_READ) | (rd_req & hit) | (done & rd_q);
    rdata_d = done & rd_q ? DMEM_READDATA : rd_req & hit ? fwd : rdata_q;
    seen_d = (rd_q | wr_q) & ~done;
    empty_d = count_q == '0 && state_q != DRAIN;
    if (state_q == IDLE && fetch_ok) begin
      state_d = FETCH;
      rd_d = 1'b1;
      daddr_d = MEM_ADDRESS;
    end else if (state_q == IDLE && count_q != '0) begin
      state_d = DRAIN;
      wr_d = 1'b1;
      daddr_d = addr_q[head_q];
      dwdata_d = data_q[head_q];
    end else if (done) begin
      state_d = IDLE;
      rd_d = 1'b0;
      wr_d = 1'b0;
    end
    wdone_d = (wdone_q | (push & MEM_READ)) & MEM_READ & ~ack_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      ack_q <= 1'b0;
      wdone_q <= 1'b0;
      seen_q <= 1'b0;
      empty_q <= 1'b1;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      daddr_q <= '0;
      dwdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      ack_q <= ack_d;
      wdone_q <= wdone_d;
      seen_q <= seen_d;
      empty_q <= empty_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      daddr_q <= daddr_d;
      dwdata_q <= dwdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[tail_q] <= MEM_ADDRESS;
      data_q[tail_q] <= MEM_WRITEDATA;
    end
  end

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) & ~ack_q;
  assign MEM_READDATA = rdata_q;
  assign DMEM_READ = rd_q;
  assign DMEM_WRITE = wr_q;
  assign DMEM_ADDRESS = daddr_q;
  assign DMEM_WRITEDATA = dwdata_q;
  assign WBUF_EMPTY = empty_q;
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: directed stimulus with a queue/shadow-memory model checked every cycle
`timescale 1ns/1ps
module tb_dcache_write_buffer;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic MEM_READ = 1'b0;
  logic MEM_WRITE = 1'b0;
  logic [5:0] MEM_ADDRESS = '0;
  logic [31:0] MEM_WRITEDATA = '0;
  logic [31:0] MEM_READDATA;
  logic MEM_BUSYWAIT;
  logic DMEM_READ;
  logic DMEM_WRITE;
  logic [5:0] DMEM_ADDRESS;
  logic [31:0] DMEM_WRITEDATA;
  logic [31:0] DMEM_READDATA;
  logic DMEM_BUSYWAIT;
  logic WBUF_EMPTY;
  typedef struct packed {logic [5:0] a; logic [31:0] d;} ent_t;
  ent_t q[$];
  logic [5:0] drained[$];
  logic [31:0] mem [64];
  logic [31:0] latest [64];
  logic hold_busy = 1'b0;
  logic exp_empty = 1'b1;
  logic prev_done = 1'b0;
  logic rd_seen = 1'b0;
  int lat = 2;
  int req_cyc = 0;
  int n_drains = 0;
  int total = 0;
  int bad = 0;

  dcache_write_buffer #(.DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE),
    .DMEM_ADDRESS(DMEM_ADDRESS), .DMEM_WRITEDATA(DMEM_WRITEDATA), .DMEM_READDATA(DMEM_READDATA),
    .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .WBUF_EMPTY(WBUF_EMPTY)
  );

  always #5 CLK = ~CLK;

  assign DMEM_BUSYWAIT = hold_busy | ((DMEM_READ | DMEM_WRITE) & (req_cyc < lat));
  assign DMEM_READDATA = mem[DMEM_ADDRESS];

  always @(posedge CLK) req_cyc <= (DMEM_READ | DMEM_WRITE) ? req_cyc + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial for (int i = 0; i < 64; i++) begin
    mem[i] = 32'hC0DE0000 | 32'(i);
    latest[i] = mem[i];
  end

  always @(negedge CLK) begin
    if (!RESET) begin
      q.delete();
      exp_empty = 1'b1;
      prev_done = 1'b0;
      for (int i = 0; i < 64; i++) latest[i] = mem[i];
    end else begin
      check("wbuf_empty", WBUF_EMPTY, exp_empty);
      if (prev_done) check("req_drop", DMEM_READ | DMEM_WRITE, 0);
      check("rd_wr_excl", DMEM_READ & DMEM_WRITE, 0);
      if (DMEM_READ) rd_seen = 1'b1;
`ifndef WBUF_FORWARD_EN
      if (DMEM_READ) check("fetch_only_when_empty", q.size(), 0);
`endif
      if (MEM_WRITE && !MEM_BUSYWAIT) begin
        q.push_back({MEM_ADDRESS, MEM_WRITEDATA});
        latest[MEM_ADDRESS] = MEM_WRITEDATA;
      end
      if (MEM_READ && !MEM_WRITE && !MEM_BUSYWAIT) check("read_data", MEM_READDATA, latest[MEM_ADDRESS]);
      exp_empty = q.size() == 0 && !DMEM_WRITE;
      prev_done = (DMEM_READ | DMEM_WRITE) && !DMEM_BUSYWAIT && req_cyc >= 1;
      if (DMEM_WRITE && prev_done) begin
        if (q.size() == 0) check("drain_unexpected", 1, 0);
        else begin
          check("drain_addr", DMEM_ADDRESS, q[0].a);
          check("drain_data", DMEM_WRITEDATA, q[0].d);
          void'(q.pop_front());
        end
        mem[DMEM_ADDRESS] = DMEM_WRITEDATA;
        drained.push_back(DMEM_ADDRESS);
        n_drains++;
      end
    end
  end

  task automatic wr(input logic [5:0] a, input logic [31:0] d, output int cyc);
    MEM_ADDRESS = a;
    MEM_WRITEDATA = d;
    MEM_WRITE = 1'b1;
    cyc = 0;
    @(negedge CLK);
    while (MEM_BUSYWAIT && cyc < 300) begin
      cyc++;
      @(negedge CLK);
    end
    if (cyc >= 300) check("write_timeout", 1, 0);
    @(posedge CLK);
    #1 MEM_WRITE = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d, output int cyc);
    MEM_ADDRESS = a;
    MEM_READ = 1'b1;
    cyc = 0;
    @(negedge CLK);
    while (MEM_BUSYWAIT && cyc < 300) begin
      cyc++;
      @(negedge CLK);
    end
    if (cyc >= 300) check("read_timeout", 1, 0);
    d = MEM_READDATA;
    @(posedge CLK);
    #1 MEM_READ = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    repeat (3) @(negedge CLK);
    while (!WBUF_EMPTY && n < 200) begin
      n++;
      @(negedge CLK);
    end
    check(name, WBUF_EMPTY, 1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n;
    logic [31:0] data;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    check("rst_dmem_read", DMEM_READ, 0);
    check("rst_dmem_write", DMEM_WRITE, 0);
    check("rst_dmem_addr", DMEM_ADDRESS, 0);
    check("rst_dmem_wdata", DMEM_WRITEDATA, 0);
    check("rst_mem_rdata", MEM_READDATA, 0);
    check("rst_empty", WBUF_EMPTY, 1);
    check("rst_busywait", MEM_BUSYWAIT, 0);
    @(posedge CLK);
    #1;

    wr(6'h05, 32'hDEADBEEF, cyc);
    check("t2_wr_latency", cyc, 1);
    n = 0;
    while (!DMEM_WRITE && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("t2_dmem_write", DMEM_WRITE, 1);
    check("t2_dmem_addr", DMEM_ADDRESS, 32'h05);
    check("t2_dmem_wdata", DMEM_WRITEDATA, 32'hDEADBEEF);
    @(posedge CLK);
    #1;
    wait_empty("t2_empty");

    drained.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr(6'(16 + i), 32'hA0000000 + 32'(i), cyc);
      check("t3_wr_latency", cyc, 1);
    end
    fork
      wr(6'h14, 32'hA0000004, cyc);
      begin
        repeat (10) @(posedge CLK);
        #1 hold_busy = 1'b0;
      end
    join
    check("t3_full_stall", cyc >= 10, 1);
    wait_empty("t3_empty");
    check("t3_drain_count", drained.size(), 5);
    for (int i = 0; i < 5 && i < drained.size(); i++) check("t3_fifo_order", drained[i], 32'(16 + i));

    hold_busy = 1'b1;
    wr(6'h0A, 32'h11111111, cyc);
    wr(6'h0A, 32'h22222222, cyc);
    rd_seen = 1'b0;
`ifdef WBUF_FORWARD_EN
    rd(6'h0A, data, cyc);
    check("t4_fwd_data", data, 32'h22222222);
    check("t4_fwd_latency", cyc, 1);
    check("t4_no_dmem_read", rd_seen, 0);
    hold_busy = 1'b0;
`else
    fork
      rd(6'h0A, data, cyc);
      begin
        repeat (6) @(posedge CLK);
        #1 hold_busy = 1'b0;
      end
    join
    check("t4_mem_data", data, 32'h22222222);
    check("t4_dmem_read", rd_seen, 1);
    check("t4_waited", cyc > 6, 1);
`endif
    wait_empty("t4_empty");

    drained.delete();
    hold_busy = 1'b1;
    wr(6'h31, 32'h31313131, cyc);
    wr(6'h32, 32'h32323232, cyc);
    rd_seen = 1'b0;
    fork
      rd(6'h20, data, cyc);
      begin
        repeat (4) @(posedge CLK);
        #1 hold_busy = 1'b0;
      end
    join
    check("t5_miss_data", data, 32'hC0DE0020);
    check("t5_dmem_read", rd_seen, 1);
`ifdef WBUF_FORWARD_EN
    check("t5_drains_before_fetch", drained.size(), 1);
`else
    check("t5_drains_before_fetch", drained.size(), 2);
`endif
    wait_empty("t5_empty");
    check("t5_total_drains", drained.size(), 2);

    hold_busy = 1'b1;
    wr(6'h01, 32'h01010101, cyc);
    wr(6'h02, 32'h02020202, cyc);
    wr(6'h03, 32'h03030303, cyc);
    n = n_drains;
    check("t6_draining", DMEM_WRITE, 1);
    RESET = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    check("t6_dmem_write_dropped", DMEM_WRITE, 0);
    check("t6_empty", WBUF_EMPTY, 1);
    @(posedge CLK);
    #1 hold_busy = 1'b0;
    repeat (20) @(negedge CLK);
    check("t6_no_more_writes", n_drains - n, 0);
    check("t6_still_empty", WBUF_EMPTY, 1);
    @(posedge CLK);
    #1;

    drained.delete();
    wr(6'h07, 32'h77777777, cyc);
    check("t7_wr_latency", cyc, 1);
    wait_empty("t7_empty");
    check("t7_drained", drained.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Posted-write buffer between the data cache's memory-side port and the data memory. Dirty-block write-backs from the data cache are enqueued in one cycle and drained to memory in the background, so the CPU stalls only for the memory read that fills the missing block. Reads bypass queued writes to other blocks and are forwarded from the buffer on a block-address match. Ports mirror the 6-bit block address, 32-bit block, READ/WRITE/BUSYWAIT protocol already used between the data cache and the data memory.

## Interface
- DEPTH, 4: number of buffered write entries (power of 2, 2..16).
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- MEM_READ  in  1  block read request from the data cache.
- MEM_WRITE  in  1  block write request from the data cache.
- MEM_ADDRESS  in  6  block address from the data cache.
- MEM_WRITEDATA  in  32  write block from the data cache.
- MEM_READDATA  out  32  read block to the data cache (registered).
- MEM_BUSYWAIT  out  1  stall to the data cache.
- DMEM_READ  out  1  read request to the data memory (registered).
- DMEM_WRITE  out  1  write request to the data memory (registered).
- DMEM_ADDRESS  out  6  block address to the data memory (registered).
- DMEM_WRITEDATA  out  32  write block to the data memory (registered).
- DMEM_READDATA  in  32  read block from the data memory.
- DMEM_BUSYWAIT  in  1  data memory busy.
- WBUF_EMPTY  out  1  high when no entries are queued and no drain is in flight.

## Operation
- Storage: circular FIFO of DEPTH {addr[5:0], data[31:0]} entries; head/tail pointers plus a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Upstream handshake: MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) & ~ack. `ack` is set on the edge a request completes and cleared on the following edge. This guarantees one enqueue per request while the cache holds the request until it sees BUSYWAIT low.
- Upstream write: completes on the first edge with MEM_WRITE=1, ack=0, count<DEPTH. The entry is written at the tail. When full, the write stalls; a slot freed by a drain is usable from the next cycle. There is no enqueue and dequeue on the same edge while full.
- Upstream read, forward hit: block address matches any queued entry, or the entry being drained. MEM_READDATA takes the youngest matching entry's data, and ack is set on the same edge.
- Upstream read, miss: the downstream FSM fetches the block from memory. MEM_READDATA is loaded with DMEM_READDATA on completion, and ack is set.
- MEM_READ and MEM_WRITE asserted together: the write is serviced first, then the read.
- Downstream FSM states:
  - IDLE → FETCH if a read miss is pending (reads have priority over drains).
  - IDLE → DRAIN if count>0.
  - DRAIN: hold DMEM_WRITE with the head entry; on completion, pop the head and go to IDLE.
  - FETCH: hold DMEM_READ; on completion, latch the data and go to IDLE.
  - A read arriving during DRAIN waits for the drain to complete.
- Downstream completion: an edge where the request is asserted, DMEM_BUSYWAIT=0, and the request has already been asserted for at least one prior cycle. The request drops on that edge.

## Timing
- Reset values:
  - DMEM_READ=0, DMEM_WRITE=0.
  - DMEM_ADDRESS=0, DMEM_WRITEDATA=0.
  - MEM_READDATA=0.
  - ack=0, FSM=IDLE, count=0.
  - WBUF_EMPTY=1.
- Reset mid-operation: all queued writes are discarded, any in-flight downstream request is dropped at that edge, and the FSM returns to IDLE.
- Write accept latency with the buffer not full: MEM_BUSYWAIT high for 1 cycle, low in cycle 2.
- Forward-hit read latency: identical to write accept.
- Miss read latency: 1 cycle to enter FETCH, plus memory latency, plus 1 cycle of ack. Any drain in progress adds its remaining time.
- Drain starts on the edge after IDLE with count>0 and no pending read.
- WBUF_EMPTY is registered, so it is valid 1 cycle after the final pop.

## Configuration
- WBUF_FORWARD_EN defined: reads that match a queued entry are forwarded as described above.
- WBUF_FORWARD_EN undefined:
  - No compare logic.
  - Every read waits until the buffer is empty and no drain is in flight, then fetches from memory. This preserves ordering without forwarding.
  - All other behaviour is unchanged.

## Test plan
- Reset with RESET=0 for 2 edges → all outputs at reset values, WBUF_EMPTY=1, MEM_BUSYWAIT=0 when no request.
- Write addr 6'h05 data 32'hDEADBEEF → MEM_BUSYWAIT low after 1 cycle. DMEM_WRITE is then asserted with addr 05 and that data, and WBUF_EMPTY returns to 1 after the drain.
- Five back-to-back writes (DEPTH=4) while DMEM_BUSYWAIT is held high → the 5th write stalls until the first drain pops, and memory receives all five in FIFO order.
- Write 6'h0A=32'h11111111 then 6'h0A=32'h22222222 (undrained), then read 0A:
  - With WBUF_FORWARD_EN: 32'h22222222 is returned in 2 cycles with no DMEM_READ.
  - Without the macro: the read completes only after both drains, returning the memory value.
- Read 6'h20 (no match) while 2 writes are queued → DMEM_READ is issued before the remaining drains, and the data returned is DMEM_READDATA.
- RESET=0 during DRAIN with 3 entries queued → DMEM_WRITE=0 on the next edge, count=0, and no further memory writes occur.
